fft_mag_squared: RTL and testbench

FFT_MAG_SQUARED -- requirements
Module: fft_mag_squared

---
 rtl/fft_mag_squared_if.sv | 42 ++++
 rtl/fft_mag_squared.sv | 104 ++++++++++
 tb/tb_fft_mag_squared.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_mag_squared_if.sv
// Stream bundle for fft_mag_squared: complex bins in,
// squared magnitudes with bin index out.
interface fft_mag_squared_if #(
  parameter int BW = 10
);
  logic [47:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [47:0]   m_data;
  logic [BW-1:0] m_bin;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          frame_err;

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output m_data,
    output m_bin,
    output m_last,
    output m_valid,
    input  m_ready,
    output frame_err
  );

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  m_data,
    input  m_bin,
    input  m_last,
    input  m_valid,
    output m_ready,
    input  frame_err
  );
endinterface

// File: rtl/fft_mag_squared.sv
// Squared magnitude of FFT bins: 3-stage pipeline with
// a single stall enable, bin tagging and frame checking.
module fft_mag_squared #(
  parameter int FRAME_LEN = 1024,
  parameter int BW        = $clog2(FRAME_LEN)
) (
  input logic              clk,
  input logic              reset,
  fft_mag_squared_if.slave bus
);

  localparam logic [BW-1:0] LAST_BIN = BW'(FRAME_LEN - 1);

  typedef struct packed {
    logic          v;
    logic [BW-1:0] bin;
    logic [23:0]   re;
    logic [23:0]   im;
  } s1_t;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] bin;
    logic [46:0]   rr;
    logic [46:0]   ii;
  } s2_t;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] bin;
    logic          last;
    logic [47:0]   sum;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  logic          en;
  logic          acc;
  logic          at_end;
  logic [BW-1:0] cnt;

  assign en     = !s3.v || bus.m_ready;
  assign acc    = bus.s_valid && en;
  assign at_end = (cnt == LAST_BIN);

  assign bus.s_ready   = en;
  assign bus.frame_err = !reset && acc
                         && (bus.s_last != at_end);

  // s_last always restarts the frame, even when early
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (acc) begin
      if (bus.s_last || at_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + BW'(1);
      end
    end
  end

  // Sign-extend to 47 bits: the low 47 product bits are exact
  logic [46:0] re_x;
  logic [46:0] im_x;
  logic [46:0] rr_c;
  logic [46:0] ii_c;
  logic [47:0] sum_c;

  assign re_x  = {{23{s1.re[23]}}, s1.re};
  assign im_x  = {{23{s1.im[23]}}, s1.im};
  assign rr_c  = re_x * re_x;
  assign ii_c  = im_x * im_x;
  assign sum_c = {1'b0, s2.rr} + {1'b0, s2.ii};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (en) begin
      s1.v    <= acc;
      s1.bin  <= cnt;
      s1.re   <= bus.s_data[23:0];
      s1.im   <= bus.s_data[47:24];
      s2.v    <= s1.v;
      s2.bin  <= s1.bin;
      s2.rr   <= rr_c;
      s2.ii   <= ii_c;
      s3.v    <= s2.v;
      s3.bin  <= s2.bin;
      s3.last <= (s2.bin == LAST_BIN);
      s3.sum  <= sum_c;
    end
  end

  assign bus.m_valid = s3.v;
  assign bus.m_data  = s3.sum;
  assign bus.m_bin   = s3.bin;
  assign bus.m_last  = s3.last;

endmodule

// File: tb/tb_fft_mag_squared.sv
// Randomized bench for fft_mag_squared with an in-bench
// queue model of bins, magnitudes and frame errors.
module tb_fft_mag_squared;

  localparam int FL = 1024;
  localparam int BW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fft_mag_squared_if #(.BW(BW)) bus ();

  fft_mag_squared #(
    .FRAME_LEN(FL),
    .BW(BW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    longint mag;
    int     bin;
    bit     last;
    int     acc;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passes = 0;

  int  ready_mode = 0;
  bit  lat_chk = 0;
  bit  lit_on = 0;
  longint lit_data = 0;

  int cyc = 0;
  int mcnt = 0;
  int err_cnt = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  int last_bin = -1;

  bit          prev_stall = 0;
  logic [47:0] prev_data;
  int          prev_bin;
  bit          prev_last;

  function automatic void chk(string nm, longint act,
                              longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, req);
  endfunction

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin : mon
    longint r;
    longint i;
    exp_t   e;
    bit     e_err;
    cyc++;
    if (reset) begin
      q.delete();
      mcnt = 0;
      prev_stall = 0;
      chk("frame_err_in_reset", longint'(bus.frame_err), 0);
    end else begin
      if (prev_stall) begin
        chk("stall_valid", longint'(bus.m_valid), 1);
        chk("stall_data", longint'(bus.m_data),
            longint'(prev_data));
        chk("stall_bin", longint'(bus.m_bin), prev_bin);
        chk("stall_last", longint'(bus.m_last),
            longint'(prev_last));
      end
      if (bus.s_valid && bus.s_ready) begin
        e_err = (bus.s_last != (mcnt == FL - 1));
        chk("frame_err", longint'(bus.frame_err),
            longint'(e_err));
        r = $signed(bus.s_data[23:0]);
        i = $signed(bus.s_data[47:24]);
        e.mag  = r * r + i * i;
        e.bin  = mcnt;
        e.last = (mcnt == FL - 1);
        e.acc  = cyc;
        q.push_back(e);
        if (bus.s_last || mcnt == FL - 1) mcnt = 0;
        else mcnt = mcnt + 1;
      end else begin
        chk("frame_err_idle", longint'(bus.frame_err), 0);
      end
      if (bus.frame_err) err_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_data", longint'(bus.m_data), e.mag);
          chk("m_bin", longint'(bus.m_bin), e.bin);
          chk("m_last", longint'(bus.m_last),
              longint'(e.last));
          if (lat_chk) chk("latency", cyc - e.acc, 3);
        end
        if (lit_on) chk("lit_data", longint'(bus.m_data),
                        lit_data);
        out_cnt++;
        if (bus.m_last) last_cnt++;
        last_bin = int'(bus.m_bin);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_bin   = int'(bus.m_bin);
      prev_last  = bus.m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] re,
                      input logic [23:0] im,
                      input bit last);
    int n = 0;
    bit ok = 0;
    bus.s_data  = {im, re};
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.s_ready;
      tick();
      n++;
    end while (!ok && n < 500);
    if (!ok) chk("send_timeout", 0, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    if (ready_mode == 2) ready_mode = 0;
    while ((q.size() != 0 || bus.m_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int o0;
    int l0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    chk("rst_m_valid", longint'(bus.m_valid), 0);
    chk("rst_m_data", longint'(bus.m_data), 0);
    chk("rst_m_bin", longint'(bus.m_bin), 0);
    chk("rst_m_last", longint'(bus.m_last), 0);
    chk("rst_frame_err", longint'(bus.frame_err), 0);
    chk("rst_s_ready", longint'(bus.s_ready), 1);
    tick();

    // Full frame of re=3 im=-4, always ready
    e0 = err_cnt; o0 = out_cnt; l0 = last_cnt;
    lat_chk = 1; lit_on = 1; lit_data = 25;
    for (int b = 0; b < FL; b++)
      send(24'd3, 24'hFFFFFC, b == FL - 1);
    drain();
    lat_chk = 0; lit_on = 0;
    chk("t1_out_count", out_cnt - o0, FL);
    chk("t1_last_count", last_cnt - l0, 1);
    chk("t1_err_count", err_cnt - e0, 0);
    chk("t1_final_bin", last_bin, FL - 1);

    // Three frames, random gaps and random backpressure
    ready_mode = 1;
    e0 = err_cnt; o0 = out_cnt; l0 = last_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < FL; b++) begin
        logic [23:0] re;
        logic [23:0] im;
        if ($urandom_range(0, 1) == 1) tick();
        case ($urandom_range(0, 7))
          0:       begin re = 24'h800000; im = 24'h800000; end
          1:       begin re = 24'h7FFFFF; im = 24'h800000; end
          default: begin re = 24'($urandom); im = 24'($urandom); end
        endcase
        send(re, im, b == FL - 1);
      end
    end
    drain();
    chk("t3_out_count", out_cnt - o0, 3 * FL);
    chk("t3_last_count", last_cnt - l0, 3);
    chk("t3_err_count", err_cnt - e0, 0);

    // Early s_last on bin 500
    e0 = err_cnt;
    for (int b = 0; b < 500; b++)
      send(24'(b), 24'd1, 1'b0);
    send(24'd7, 24'd7, 1'b1);
    send(24'd2, 24'd0, 1'b0);
    drain();
    chk("t4_err_count", err_cnt - e0, 1);
    chk("t4_next_bin", last_bin, 0);

    // Missing s_last on bin 1023
    e0 = err_cnt;
    for (int b = 1; b < FL - 1; b++)
      send(24'd1, 24'(b), 1'b0);
    send(24'd5, 24'd5, 1'b0);
    send(24'd1, 24'd1, 1'b0);
    drain();
    chk("t5_err_count", err_cnt - e0, 1);
    chk("t5_next_bin", last_bin, 0);

    // Worst-case magnitude
    o0 = out_cnt;
    lit_on = 1; lit_data = 48'h8000_0000_0000;
    send(24'h800000, 24'h800000, 1'b0);
    drain();
    lit_on = 0;
    chk("t2_out_count", out_cnt - o0, 1);

    // Reset with three beats stalled in flight
    ready_mode = 2;
    tick();
    tick();
    o0 = out_cnt;
    send(24'd1, 24'd1, 1'b0);
    send(24'd2, 24'd2, 1'b0);
    send(24'd3, 24'd3, 1'b0);
    tick();
    chk("t6_stalled_valid", longint'(bus.m_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("t6_m_valid", longint'(bus.m_valid), 0);
    chk("t6_m_data", longint'(bus.m_data), 0);
    chk("t6_m_bin", longint'(bus.m_bin), 0);
    chk("t6_s_ready", longint'(bus.s_ready), 1);
    tick();
    ready_mode = 1;
    send(24'd6, 24'd8, 1'b0);
    drain();
    chk("t6_out_count", out_cnt - o0, 1);
    chk("t6_first_bin", last_bin, 0);

    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
